data_op_unit: RTL and testbench
===============================

# data_op_unit

Parametrised, flow-controlled successor to the 8-bit control-word data operator in the washing-machine controller datapath. Accepts an operand plus 3-bit opcode over a valid/ready handshake, computes the result in one registered stage, and holds it until the consumer takes it. Adds configurable width and step sizes, optional saturation, sticky overflow/underflow/illegal-op flags, and a transaction counter.

## Interface
- WIDTH, 8, operand/result width (≥ 4)
- DEC_STEP, 1, subtrahend for opcode 001 (< 2^WIDTH)
- INC_STEP, 2, addend for opcode 010 (< 2^WIDTH)
- SATURATE, 0, 1 = clamp add/sub results; 0 = wrap modulo 2^WIDTH
- CNT_WIDTH, 16, width of op_count
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  unit can accept this cycle
- ctrl  input  3  opcode
- data_in  input  WIDTH  operand
- out_valid  output  1  data_out holds an untaken result
- out_ready  input  1  consumer takes result this cycle
- data_out  output  WIDTH  registered result
- clr_status  input  1  synchronous clear of sticky flags and op_count
- status  output  8  flag vector (see Operation)
- op_count  output  CNT_WIDTH  accepted transactions, wraps

## Operation
- Accept = in_valid && in_ready. On accept, data_out/flags load next edge, out_valid=1.
- Opcodes: 000 → 0; 001 → data_in − DEC_STEP; 010 → data_in + INC_STEP; 011 → ~data_in; 100 → data_in; 101 → data_in << 1 (LSB 0, MSB dropped); 110 → data_in >> 1 logical; 111 → illegal, result 0.
- Add/sub computed in WIDTH+1 bits. Carry out on 010 = overflow; borrow on 001 = underflow. SATURATE=1: overflow → all-ones, underflow → 0. SATURATE=0: wrap. Shift-out of a 1 on 101 is not overflow.
- status[0] = out_valid.
- status[1] = post-reset idle: 1 from reset until first accept, then 0 (clr_status does not set it).
- status[2] sticky overflow, status[3] sticky underflow, status[4] sticky illegal opcode; set on the accept cycle that causes them.
- status[5] = enable: 1 when held result came from 001 or 010, else 0.
- status[6] = held result equals 0.
- status[7] = 0.
- op_count increments on every accept, including illegal opcodes.
- clr_status: clears status[4:2] and op_count. Same-cycle accept wins its contribution: flag it sets stays 1, op_count becomes 1.

## Timing
- Reset (rst_n low, asynchronous): data_out=0, out_valid=0, status=8'b0000_0010, op_count=0, sticky flags 0; in_ready forced 0 while rst_n low.
- in_ready = !out_valid || out_ready (combinational, no bubble). Throughput 1 result/cycle with out_ready held high.
- Latency: accept at edge N → data_out valid after edge N, visible cycle N+1.
- Stall: out_valid && !out_ready → data_out, status[6:5] frozen, in_ready=0, inputs ignored.
- Take and accept same cycle: old result retires, new result loads same edge, out_valid stays 1.
- Take with no accept: out_valid → 0 next edge; data_out keeps last value.
- ctrl/data_in sampled only on accept; changes while in_valid low or stalled have no effect.
- Reset mid-transaction: pending result discarded, no flag/count update.
- op_count wraps 2^CNT_WIDTH−1 → 0 without flag.

## Test plan
- Reset then idle: status=0x02, out_valid=0, data_out=0; first accept ctrl=010 data_in=0x10 → data_out=0x12, status[1]=0, status[5]=1, op_count=1.
- Wrap vs saturate (WIDTH=8): ctrl=010 data_in=0xFF → 0x01 (SATURATE=0) / 0xFF (SATURATE=1), status[2]=1; ctrl=001 data_in=0x00 → 0xFF / 0x00, status[3]=1.
- Backpressure: out_ready=0 across 3 offered ops → data_out holds first result, in_ready=0, op_count=1; release → remaining ops delivered in order, one per cycle.
- Illegal and misc ops: ctrl=111 → data_out=0, status[4]=1, status[6]=1; ctrl=011 data_in=0xA5 → 0x5A; ctrl=101 0x81 → 0x02; ctrl=110 0x81 → 0x40.
- clr_status collision: clr_status with accept of ctrl=111 → status[4]=1, op_count=1; clr_status alone → status[4:2]=0, op_count=0.
- Async reset mid-stall: drop rst_n between edges with out_valid=1 → outputs at reset values immediately, no further update until rst_n high.

Source files
------------

// File: rtl/data_op_if.sv
// Handshake bundle for data_op_unit: operand/opcode in, registered result out.
interface data_op_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;

  modport slave (
    input  in_valid, ctrl, data_in, out_ready,
    output in_ready, out_valid, data_out
  );

  modport master (
    output in_valid, ctrl, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );
endinterface

// File: rtl/data_op_unit.sv
// Flow-controlled single-stage data operator with optional saturation,
// sticky overflow/underflow/illegal flags and a wrapping transaction counter.
module data_op_unit #(
  parameter int WIDTH     = 8,
  parameter int DEC_STEP  = 1,
  parameter int INC_STEP  = 2,
  parameter bit SATURATE  = 1'b0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_op_if.slave             bus,
  input  logic                 clr_status,
  output logic [7:0]           status,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam logic [WIDTH:0]     INC_EXT = (WIDTH+1)'(INC_STEP);
  localparam logic [WIDTH:0]     DEC_EXT = (WIDTH+1)'(DEC_STEP);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [WIDTH-1:0] clamp_add(input logic [WIDTH:0] s);
    if (SATURATE && s[WIDTH]) return '1;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] clamp_sub(input logic [WIDTH:0] d);
    if (SATURATE && d[WIDTH]) return '0;
    return d[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   sum_p0, diff_p0;
  logic [WIDTH-1:0] res_p0;
  logic             ovf_p0, unf_p0, ill_p0, en_p0;
  logic             accept;

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1, en_p1, zero_p1, idle_p1;
  logic             ovf_st, unf_st, ill_st;

  assign bus.in_ready = rst_n && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage p0: decode opcode and compute the candidate result
  assign sum_p0  = {1'b0, bus.data_in} + INC_EXT;
  assign diff_p0 = {1'b0, bus.data_in} - DEC_EXT;

  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    unf_p0 = 1'b0;
    ill_p0 = 1'b0;
    en_p0  = 1'b0;
    case (bus.ctrl)
      3'b000: res_p0 = '0;
      3'b001: begin
        res_p0 = clamp_sub(diff_p0);
        unf_p0 = diff_p0[WIDTH];
        en_p0  = 1'b1;
      end
      3'b010: begin
        res_p0 = clamp_add(sum_p0);
        ovf_p0 = sum_p0[WIDTH];
        en_p0  = 1'b1;
      end
      3'b011: res_p0 = ~bus.data_in;
      3'b100: res_p0 = bus.data_in;
      3'b101: res_p0 = {bus.data_in[WIDTH-2:0], 1'b0};
      3'b110: res_p0 = {1'b0, bus.data_in[WIDTH-1:1]};
      default: ill_p0 = 1'b1;
    endcase
  end

  // Stage p1: hold result until taken; accept in the same cycle as clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      en_p1    <= 1'b0;
      zero_p1  <= 1'b0;
      idle_p1  <= 1'b1;
      ovf_st   <= 1'b0;
      unf_st   <= 1'b0;
      ill_st   <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        data_p1 <= res_p0;
        vld_p1  <= 1'b1;
        en_p1   <= en_p0;
        zero_p1 <= (res_p0 == '0);
        idle_p1 <= 1'b0;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
      ovf_st <= (ovf_st && !clr_status) || (accept && ovf_p0);
      unf_st <= (unf_st && !clr_status) || (accept && unf_p0);
      ill_st <= (ill_st && !clr_status) || (accept && ill_p0);
      if (accept)
        op_count <= clr_status ? CNT_ONE : op_count + CNT_ONE;
      else if (clr_status)
        op_count <= '0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.data_out  = data_p1;
  assign status = {1'b0, zero_p1, en_p1, ill_st, unf_st, ovf_st, idle_p1, vld_p1};

endmodule

// File: tb/tb_data_op_unit.sv
// Directed bench for data_op_unit: a wrapping instance plus a saturating
// instance with a 2-bit counter, both fed from the same stimulus.
module tb_data_op_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_status = 1'b0;
  logic [7:0]  status, status_s;
  logic [15:0] op_count;
  logic [1:0]  op_count_s;

  int n_checks = 0;
  int n_errors = 0;

  data_op_if #(.WIDTH(8)) dif ();
  data_op_if #(.WIDTH(8)) sif ();

  assign sif.in_valid  = dif.in_valid;
  assign sif.ctrl      = dif.ctrl;
  assign sif.data_in   = dif.data_in;
  assign sif.out_ready = dif.out_ready;

  data_op_unit #(.WIDTH(8), .DEC_STEP(1), .INC_STEP(2), .SATURATE(1'b0), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(dif.slave),
    .clr_status(clr_status), .status(status), .op_count(op_count)
  );

  data_op_unit #(.WIDTH(8), .DEC_STEP(1), .INC_STEP(2), .SATURATE(1'b1), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave),
    .clr_status(clr_status), .status(status_s), .op_count(op_count_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] d);
    dif.in_valid = 1'b1;
    dif.ctrl     = c;
    dif.data_in  = d;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
  endtask

  initial begin
    dif.in_valid  = 1'b0;
    dif.ctrl      = 3'b000;
    dif.data_in   = 8'h00;
    dif.out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(dif.in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("idle_status", 32'(status), 32'h02);
    chk("idle_out_valid", 32'(dif.out_valid), 32'h0);
    chk("idle_data_out", 32'(dif.data_out), 32'h00);
    chk("idle_op_count", 32'(op_count), 32'h0);
    chk("idle_in_ready", 32'(dif.in_ready), 32'h1);

    send(3'b010, 8'h10);
    chk("inc_data", 32'(dif.data_out), 32'h12);
    chk("inc_status", 32'(status), 32'h21);
    chk("inc_count", 32'(op_count), 32'h1);

    send(3'b010, 8'hFF);
    chk("ovf_wrap_data", 32'(dif.data_out), 32'h01);
    chk("ovf_sat_data", 32'(sif.data_out), 32'hFF);
    chk("ovf_wrap_status", 32'(status), 32'h25);
    chk("ovf_sat_status", 32'(status_s), 32'h25);

    send(3'b001, 8'h00);
    chk("unf_wrap_data", 32'(dif.data_out), 32'hFF);
    chk("unf_sat_data", 32'(sif.data_out), 32'h00);
    chk("unf_wrap_status", 32'(status), 32'h2D);
    chk("unf_sat_status", 32'(status_s), 32'h6D);
    chk("unf_count", 32'(op_count), 32'h3);

    send(3'b011, 8'hA5);
    chk("not_data", 32'(dif.data_out), 32'h5A);
    send(3'b101, 8'h81);
    chk("shl_data", 32'(dif.data_out), 32'h02);
    chk("shl_no_ovf", 32'(status), 32'h0D);
    send(3'b110, 8'h81);
    chk("shr_data", 32'(dif.data_out), 32'h40);
    send(3'b100, 8'h3C);
    chk("pass_data", 32'(dif.data_out), 32'h3C);
    send(3'b000, 8'h77);
    chk("zero_data", 32'(dif.data_out), 32'h00);
    chk("zero_status", 32'(status), 32'h4D);
    send(3'b111, 8'h55);
    chk("ill_data", 32'(dif.data_out), 32'h00);
    chk("ill_status", 32'(status), 32'h5D);
    chk("ill_count", 32'(op_count), 32'h9);
    chk("sat_count_wrap", 32'(op_count_s), 32'h1);

    @(posedge clk); #1;
    chk("take_out_valid", 32'(dif.out_valid), 32'h0);
    chk("take_data_kept", 32'(dif.data_out), 32'h00);
    chk("take_status", 32'(status), 32'h5C);

    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
    chk("clr_status", 32'(status), 32'h40);
    chk("clr_count", 32'(op_count), 32'h0);

    clr_status = 1'b1;
    send(3'b111, 8'h00);
    clr_status = 1'b0;
    chk("clr_acc_status", 32'(status), 32'h51);
    chk("clr_acc_count", 32'(op_count), 32'h1);

    send(3'b010, 8'h01);
    chk("bp_first", 32'(dif.data_out), 32'h03);
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.ctrl      = 3'b100;
    dif.data_in   = 8'h20;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 32'(dif.data_out), 32'h03);
      chk("bp_in_ready", 32'(dif.in_ready), 32'h0);
      chk("bp_count", 32'(op_count), 32'h2);
    end
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_b", 32'(dif.data_out), 32'h20);
    chk("bp_rel_b_count", 32'(op_count), 32'h3);
    dif.ctrl    = 3'b110;
    dif.data_in = 8'h80;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    chk("bp_rel_c", 32'(dif.data_out), 32'h40);
    chk("bp_rel_c_valid", 32'(dif.out_valid), 32'h1);
    chk("bp_rel_c_count", 32'(op_count), 32'h4);

    send(3'b011, 8'h00);
    chk("pre_rst_data", 32'(dif.data_out), 32'hFF);
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.ctrl      = 3'b010;
    dif.data_in   = 8'h05;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(dif.data_out), 32'h00);
    chk("arst_valid", 32'(dif.out_valid), 32'h0);
    chk("arst_status", 32'(status), 32'h02);
    chk("arst_count", 32'(op_count), 32'h0);
    chk("arst_in_ready", 32'(dif.in_ready), 32'h0);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_hold_data", 32'(dif.data_out), 32'h00);
    chk("arst_hold_status", 32'(status), 32'h02);
    dif.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_status", 32'(status), 32'h02);
    chk("post_rst_count", 32'(op_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
